// File: rtl/serial_adder.sv
// Multi-cycle ripple adder: adds WIDTH-bit operands DIGIT bits per clock with a start/busy/done handshake.
// Define SERIAL_ADDER_SUB_EN to add the sub port and two's-complement subtraction.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);

  generate
    if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_cfg
      $error("serial_adder: DIGIT must divide WIDTH and WIDTH must be >= 2");
    end
  endgenerate

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   acc_r;
  logic               carry_r;
  logic [CW-1:0]      cnt_r;

  logic               accept_s;
  logic               step_s;
  logic               last_s;
  logic [WIDTH-1:0]   b_in_s;
  logic               cin_in_s;
  logic [DIGIT-1:0]   slice_sum_s;
  logic               slice_cout_s;
  logic               msb_cin_s;
  logic [WIDTH-1:0]   acc_nxt_s;

  // Operand conditioning: subtraction becomes a + ~b + 1, so cin is ignored then.
`ifdef SERIAL_ADDER_SUB_EN
  always_comb begin
    if (sub) begin
      b_in_s   = ~b;
      cin_in_s = 1'b1;
    end else begin
      b_in_s   = b;
      cin_in_s = cin;
    end
  end
`else
  always_comb begin
    b_in_s   = b;
    cin_in_s = cin;
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == CW'(N - 1)) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM decode: accept a request, advance one digit, or finish.
  always_comb begin
    accept_s = 1'b0;
    step_s   = 1'b0;
    last_s   = 1'b0;
    case (state_r)
      IDLE: accept_s = start;
      RUN: begin
        step_s = 1'b1;
        last_s = (cnt_r == CW'(N - 1));
      end
      default: begin
        accept_s = 1'b0;
        step_s   = 1'b0;
        last_s   = 1'b0;
      end
    endcase
  end

  // DIGIT-bit ripple slice; msb_cin_s keeps the carry into the slice's top bit for overflow.
  always_comb begin : slice
    logic c_v;
    c_v         = carry_r;
    slice_sum_s = '0;
    msb_cin_s   = 1'b0;
    for (int i = 0; i < DIGIT; i++) begin
      msb_cin_s      = c_v;
      slice_sum_s[i] = a_r[i] ^ b_r[i] ^ c_v;
      c_v            = (a_r[i] & b_r[i]) | (c_v & (a_r[i] ^ b_r[i]));
    end
    slice_cout_s = c_v;
  end

  // New sum digits enter from the MSB side so the result is aligned after N steps.
  always_comb begin
    acc_nxt_s = (acc_r >> DIGIT) | (WIDTH'(slice_sum_s) << (WIDTH - DIGIT));
  end

  // Operand/carry/result shift registers and digit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      acc_r   <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
    end else if (accept_s) begin
      a_r     <= a;
      b_r     <= b_in_s;
      acc_r   <= '0;
      carry_r <= cin_in_s;
      cnt_r   <= '0;
    end else if (step_s) begin
      a_r     <= a_r >> DIGIT;
      b_r     <= b_r >> DIGIT;
      acc_r   <= acc_nxt_s;
      carry_r <= slice_cout_s;
      cnt_r   <= cnt_r + CW'(1);
    end else begin
      a_r     <= a_r;
      b_r     <= b_r;
      acc_r   <= acc_r;
      carry_r <= carry_r;
      cnt_r   <= cnt_r;
    end
  end

  // Registered handshake and result outputs; results only move on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      busy <= (state_nxt_s == RUN);
      done <= last_s;
      if (last_s) begin
        sum  <= acc_nxt_s;
        cout <= slice_cout_s;
        ovf  <= msb_cin_s ^ slice_cout_s;
      end else begin
        sum  <= sum;
        cout <= cout;
        ovf  <= ovf;
      end
    end
  end

endmodule
